debug_ctrl: RTL and testbench

- Run-control sequencer for the single-cycle RV32I core.
- Gates the core's state updates (PC, regfile, LSU writes) through one enable, and owns the core's reset.
- Accepts halt/run/step/breakpoint commands over a valid/ready port from a host or debug UART bridge.
- Counts retired instructions; in a single-cycle core, every enabled cycle retires exactly one instruction.

---
 rtl/dbg_pkg.sv | 30 +++
 rtl/bp_unit.sv | 52 +++++
 rtl/debug_ctrl.sv | 158 +++++++++++++++
 tb/tb_debug_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types for the debug run-control block: FSM states, command opcodes, halt causes.
// Purely declarative; no logic, no latency, no flow control.
package dbg_pkg;

    typedef enum logic [1:0] {
        CRST   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } dbg_state_e;

    typedef enum logic [2:0] {
        OP_HALT       = 3'd0,
        OP_RUN        = 3'd1,
        OP_STEP       = 3'd2,
        OP_SET_BP     = 3'd3,
        OP_CLR_BP     = 3'd4,
        OP_RESET_CORE = 3'd5
    } dbg_op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_HALT = 2'd1,
        CAUSE_BKPT = 2'd2,
        CAUSE_STEP = 2'd3
    } halt_cause_e;

    localparam int STEP_W = 16;

endpackage

// File: rtl/bp_unit.sv
// PC breakpoint comparators with a lowest-index-wins priority encoder.
// Writes land next cycle; match is combinational on the current pc; no backpressure.
module bp_unit #(
    parameter int NBKPT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic        clr,
    input  logic [2:0]  idx,
    input  logic [29:0] addr,
    input  logic [29:0] pc_word,
    output logic        match,
    output logic [2:0]  match_idx
);

    logic [29:0]      bp_addr [NBKPT];
    logic [NBKPT-1:0] bp_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            bp_vld <= '0;
            for (int i = 0; i < NBKPT; i++) begin
                bp_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBKPT; i++) begin
                if (idx == 3'(i)) begin
                    if (set) begin
                        bp_vld[i]  <= 1'b1;
                        bp_addr[i] <= addr;
                    end else if (clr) begin
                        bp_vld[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        match     = 1'b0;
        match_idx = 3'd0;
        for (int i = NBKPT - 1; i >= 0; i--) begin
            if (bp_vld[i] && (bp_addr[i] == pc_word)) begin
                match     = 1'b1;
                match_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/debug_ctrl.sv
// Run-control sequencer for the single-cycle core: core reset, commit gating, breakpoints, stepping.
// core_en is combinational from state and pc; commands accepted any non-reset cycle, no buffering.
module debug_ctrl
    import dbg_pkg::*;
#(
    parameter int NBKPT        = 4,
    parameter int RST_CYCLES   = 4,
    parameter bit START_HALTED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_idx,
    input  logic [31:0] cmd_data,
    output logic        core_en,
    output logic        core_rst_n,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [2:0]  bp_idx,
    output logic        cmd_err,
    output logic [31:0] instret
);

    localparam int            HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_CYCLES - 1);

    dbg_state_e          state;
    logic [HW-1:0]       hold_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   step_load;
    logic                skip;

    logic                accept;
    logic                is_halt, is_run, is_step, is_set, is_clr, is_rcore, is_illegal;
    logic                idx_ok, busy_run, bad;
    logic                bp_match;
    logic [2:0]          bp_hit_idx;
    logic                pc_unused;

    assign pc_unused = ^pc[1:0];

    assign cmd_ready = (state != CRST);
    assign halted    = (state == HALTED);
    assign accept    = cmd_valid && cmd_ready;

    assign is_halt    = accept && (cmd_op == OP_HALT);
    assign is_run     = accept && (cmd_op == OP_RUN);
    assign is_step    = accept && (cmd_op == OP_STEP);
    assign is_set     = accept && (cmd_op == OP_SET_BP);
    assign is_clr     = accept && (cmd_op == OP_CLR_BP);
    assign is_rcore   = accept && (cmd_op == OP_RESET_CORE);
    assign is_illegal = accept && (cmd_op > 3'd5);

    assign idx_ok   = ({1'b0, cmd_idx} < 4'(NBKPT));
    assign busy_run = (state == RUN) || (state == STEP);
    assign bad      = is_illegal
                   || ((is_set || is_clr) && !idx_ok)
                   || ((is_run || is_step) && busy_run);

    assign step_load = (cmd_data[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_data[STEP_W-1:0];

    bp_unit #(.NBKPT(NBKPT)) u_bp (
        .clk       (clk),
        .rst       (rst),
        .set       (is_set && idx_ok),
        .clr       (is_clr && idx_ok),
        .idx       (cmd_idx),
        .addr      (cmd_data[31:2]),
        .pc_word   (pc[31:2]),
        .match     (bp_match),
        .match_idx (bp_hit_idx)
    );

    // Halting must happen before the matched instruction commits, so this cannot be registered.
    always_comb begin
        core_en = 1'b0;
        case (state)
            RUN:     core_en = !(bp_match && !skip);
            STEP:    core_en = 1'b1;
            default: core_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CRST;
            hold_cnt   <= HOLD_INIT;
            step_cnt   <= '0;
            skip       <= 1'b0;
            core_rst_n <= 1'b0;
            halt_cause <= CAUSE_NONE;
            bp_idx     <= 3'd0;
            cmd_err    <= 1'b0;
            instret    <= '0;
        end else begin
            cmd_err <= bad;
            if (core_en) begin
                instret <= instret + 32'd1;
                skip    <= 1'b0;
            end
            if (is_rcore) begin
                state      <= CRST;
                hold_cnt   <= HOLD_INIT;
                core_rst_n <= 1'b0;
                instret    <= '0;
                skip       <= 1'b0;
            end else begin
                case (state)
                    CRST: begin
                        if (hold_cnt == '0) begin
                            state      <= START_HALTED ? HALTED : RUN;
                            core_rst_n <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                    end
                    RUN: begin
                        // A breakpoint outranks a HALT command arriving in the same cycle.
                        if (bp_match && !skip) begin
                            state      <= HALTED;
                            halt_cause <= CAUSE_BKPT;
                            bp_idx     <= bp_hit_idx;
                        end else if (is_halt) begin
                            state      <= HALTED;
                            halt_cause <= CAUSE_HALT;
                        end
                    end
                    HALTED: begin
                        if (is_run) begin
                            state <= RUN;
                            skip  <= 1'b1;
                        end else if (is_step) begin
                            state    <= STEP;
                            step_cnt <= step_load;
                            skip     <= 1'b1;
                        end
                    end
                    STEP: begin
                        if (is_halt) begin
                            state      <= HALTED;
                            halt_cause <= CAUSE_HALT;
                        end else if (step_cnt == STEP_W'(1)) begin
                            state      <= HALTED;
                            halt_cause <= CAUSE_STEP;
                        end else begin
                            step_cnt <= step_cnt - STEP_W'(1);
                        end
                    end
                    default: state <= CRST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_ctrl.sv
// Directed bench for debug_ctrl with a tiny core model advancing pc by 4 per enabled cycle.
// Inputs change and outputs are sampled on the falling edge.
module tb_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc = '0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_idx;
    logic [31:0] cmd_data;
    logic        core_en;
    logic        core_rst_n;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [2:0]  bp_idx;
    logic        cmd_err;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  idx;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [7];

    debug_ctrl #(.NBKPT(4), .RST_CYCLES(4), .START_HALTED(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_idx    (cmd_idx),
        .cmd_data   (cmd_data),
        .core_en    (core_en),
        .core_rst_n (core_rst_n),
        .halted     (halted),
        .halt_cause (halt_cause),
        .bp_idx     (bp_idx),
        .cmd_err    (cmd_err),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Core model: pc resets to 0 and advances one word per committed instruction.
    always @(posedge clk) begin
        if (!core_rst_n)  pc <= '0;
        else if (core_en) pc <= pc + 32'd4;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] idx, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_idx   = 3'd0;
        cmd_data  = '0;
    endtask

    // Counts falling edges with core_rst_n low, starting at the current one.
    task automatic wait_crst(input string name);
        int  n;
        logic rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        while (!core_rst_n && n < 20) begin
            if (cmd_ready) rdy_seen = 1'b1;
            n++;
            tick();
        end
        check({name, "_len"}, n, 4);
        check({name, "_ready_low"}, {31'd0, rdy_seen}, 0);
    endtask

    task automatic wait_halted(input string name, output int en_cycles);
        int n;
        n = 0;
        en_cycles = 0;
        while (!halted && n < 100) begin
            if (core_en) en_cycles++;
            n++;
            tick();
        end
        check({name, "_halted"}, {31'd0, halted}, 1);
    endtask

    initial begin
        int n;
        int en;

        vecs[0] = '{3'd7, 3'd0, 32'h0,   1'b1};
        vecs[1] = '{3'd6, 3'd0, 32'h0,   1'b1};
        vecs[2] = '{3'd3, 3'd5, 32'h40,  1'b1};
        vecs[3] = '{3'd4, 3'd4, 32'h0,   1'b1};
        vecs[4] = '{3'd3, 3'd3, 32'h100, 1'b0};
        vecs[5] = '{3'd4, 3'd3, 32'h0,   1'b0};
        vecs[6] = '{3'd0, 3'd0, 32'h0,   1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_idx   = 3'd0;
        cmd_data  = '0;
        tick();
        tick();

        // Reset values
        check("rst_core_rst_n", {31'd0, core_rst_n}, 0);
        check("rst_cmd_ready",  {31'd0, cmd_ready}, 0);
        check("rst_halted",     {31'd0, halted}, 0);
        check("rst_cause",      {30'd0, halt_cause}, 0);
        check("rst_cmd_err",    {31'd0, cmd_err}, 0);
        check("rst_instret",    instret, 0);
        check("rst_core_en",    {31'd0, core_en}, 0);
        rst = 1'b0;
        wait_crst("crst0");
        check("boot_halted",  {31'd0, halted}, 1);
        check("boot_cause",   {30'd0, halt_cause}, 0);
        check("boot_core_en", {31'd0, core_en}, 0);
        check("boot_instret", instret, 0);
        check("boot_ready",   {31'd0, cmd_ready}, 1);

        // Breakpoint halt before the matched instruction commits
        send(3'd3, 3'd0, 32'h10);
        send(3'd1, 3'd0, 32'h0);
        n = 0;
        while (core_en && n < 50) begin
            n++;
            tick();
        end
        check("bp0_pc_at_block", pc, 32'h10);
        check("bp0_core_en_low", {31'd0, core_en}, 0);
        tick();
        check("bp0_halted",  {31'd0, halted}, 1);
        check("bp0_cause",   {30'd0, halt_cause}, 2);
        check("bp0_idx",     {29'd0, bp_idx}, 0);
        check("bp0_instret", instret, 4);
        check("bp0_pc_hold", pc, 32'h10);

        // Resume from the breakpoint: the matched instruction commits
        send(3'd1, 3'd0, 32'h0);
        check("resume_core_en", {31'd0, core_en}, 1);
        tick();
        check("resume_pc",      pc, 32'h14);
        check("resume_instret", instret, 5);

        // HALT in RUN: current instruction still commits
        send(3'd0, 3'd0, 32'h0);
        check("halt_halted",  {31'd0, halted}, 1);
        check("halt_cause",   {30'd0, halt_cause}, 1);
        check("halt_instret", instret, 6);
        check("halt_pc",      pc, 32'h18);

        // STEP 3 then STEP 0
        send(3'd2, 3'd0, 32'd3);
        wait_halted("step3", en);
        check("step3_en_cycles", en, 3);
        check("step3_cause",     {30'd0, halt_cause}, 3);
        check("step3_instret",   instret, 9);
        check("step3_pc",        pc, 32'h24);
        send(3'd2, 3'd0, 32'd0);
        wait_halted("step0", en);
        check("step0_en_cycles", en, 1);
        check("step0_instret",   instret, 10);
        check("step0_pc",        pc, 32'h28);

        // Command legality table, applied while halted
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].idx, vecs[i].data);
            check($sformatf("vec%0d_err", i), {31'd0, cmd_err}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_halted", i), {31'd0, halted}, 1);
            tick();
            check($sformatf("vec%0d_err_pulse", i), {31'd0, cmd_err}, 0);
        end

        // Rejected RUN/STEP while running
        send(3'd1, 3'd0, 32'h0);
        send(3'd2, 3'd0, 32'd5);
        check("run_step_err",    {31'd0, cmd_err}, 1);
        check("run_step_state",  {31'd0, halted}, 0);
        check("run_step_en",     {31'd0, core_en}, 1);
        tick();
        check("run_step_pulse",  {31'd0, cmd_err}, 0);
        send(3'd1, 3'd0, 32'h0);
        check("run_run_err",     {31'd0, cmd_err}, 1);

        // Breakpoint and HALT in the same cycle: breakpoint wins
        send(3'd3, 3'd1, 32'h80);
        check("setbp_run_err", {31'd0, cmd_err}, 0);
        n = 0;
        while (pc !== 32'h80 && n < 100) begin
            n++;
            tick();
        end
        check("bp1_pc", pc, 32'h80);
        check("bp1_en_low", {31'd0, core_en}, 0);
        send(3'd0, 3'd0, 32'h0);
        check("bp1_halted", {31'd0, halted}, 1);
        check("bp1_cause",  {30'd0, halt_cause}, 2);
        check("bp1_idx",    {29'd0, bp_idx}, 1);

        // Two comparators on one address: lowest index reported, low bits ignored
        send(3'd3, 3'd3, 32'h87);
        send(3'd3, 3'd2, 32'h84);
        send(3'd1, 3'd0, 32'h0);
        wait_halted("bp23", en);
        check("bp23_pc",    pc, 32'h84);
        check("bp23_idx",   {29'd0, bp_idx}, 2);
        check("bp23_cause", {30'd0, halt_cause}, 2);

        // RESET_CORE while running; breakpoints survive
        send(3'd1, 3'd0, 32'h0);
        tick();
        send(3'd5, 3'd0, 32'h0);
        check("rcore_instret", instret, 0);
        check("rcore_rst_n",   {31'd0, core_rst_n}, 0);
        wait_crst("crst1");
        check("rcore_halted", {31'd0, halted}, 1);
        check("rcore_pc",     pc, 32'h0);
        send(3'd1, 3'd0, 32'h0);
        wait_halted("rcore_bp", en);
        check("rcore_bp_pc",      pc, 32'h10);
        check("rcore_bp_idx",     {29'd0, bp_idx}, 0);
        check("rcore_bp_instret", instret, 4);

        // Block reset in the middle of a STEP
        send(3'd2, 3'd0, 32'd10);
        tick();
        check("midstep_running", {31'd0, halted}, 0);
        check("midstep_en",      {31'd0, core_en}, 1);
        rst = 1'b1;
        tick();
        check("rst2_core_rst_n", {31'd0, core_rst_n}, 0);
        check("rst2_ready",      {31'd0, cmd_ready}, 0);
        check("rst2_halted",     {31'd0, halted}, 0);
        check("rst2_cause",      {30'd0, halt_cause}, 0);
        check("rst2_instret",    instret, 0);
        check("rst2_core_en",    {31'd0, core_en}, 0);
        rst = 1'b0;
        wait_crst("crst2");
        send(3'd1, 3'd0, 32'h0);
        repeat (8) tick();
        check("rst2_bp_cleared", {31'd0, halted}, 0);
        check("rst2_run_pc",     pc, 32'h20);
        check("rst2_run_instret", instret, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
